bram_stream_rd: RTL and testbench
=================================

# bram_stream_rd

Read-side companion to `bram_ctrl`: on a run command it fetches `i_cnt` consecutive words from one port of `true_dpbram`, starting at `i_base`. It delivers them in order on a valid/ready stream, absorbing the BRAM's 1-cycle read latency and downstream backpressure with a 2-entry output FIFO. It never writes memory; the write side is owned by `bram_ctrl` or by the other BRAM port.

## Interface
- `DATA_WIDTH`, 16: memory/stream word width
- `ADDR_WIDTH`, 7: address width
- `MEM_SIZE`, 128: words in the memory; addresses wrap modulo `MEM_SIZE`
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset: one clock; synchronous and active-high (asserted = 1; the name is kept identical to `bram_ctrl`)
- `i_run`  in  1  start request, accepted only while `o_idle`=1
- `i_base`  in  ADDR_WIDTH  first address, sampled with `i_run`
- `i_cnt`  in  ADDR_WIDTH  word count, sampled with `i_run`; 0 is legal
- `o_idle`  out  1  state IDLE
- `o_busy`  out  1  state RUN or DRAIN
- `o_done`  out  1  one-cycle pulse, state DONE
- `addr`  out  ADDR_WIDTH  BRAM address
- `en`  out  1  BRAM read enable
- `we`  out  1  constant 0
- `qout`  in  DATA_WIDTH  BRAM read data, valid the cycle after `en`
- `o_valid`  out  1  stream data valid
- `o_data`  out  DATA_WIDTH  stream data
- `i_ready`  in  1  downstream accept; a transfer occurs when `o_valid & i_ready`

## Operation
- FSM states and transitions:
  - IDLE -> RUN on `i_run`.
  - IDLE -> DONE on `i_run` when `i_cnt`=0.
  - RUN -> DRAIN when the issued count reaches `cnt`.
  - DRAIN -> DONE when the FIFO is empty and no read is in flight.
  - DONE -> IDLE unconditionally.
- `i_run` is ignored outside IDLE. `i_base` and `i_cnt` are registered at acceptance; later changes have no effect.
- RUN: the issue counter and address start at 0 and `i_base`.
  - A read is issued (`en`=1) when `count + inflight - pop < 2`, where `pop` = transfer this cycle.
  - Address wrap: if `addr == MEM_SIZE-1`, the next address is 0; otherwise `addr+1`. This uses an explicit compare, so a non-power-of-2 `MEM_SIZE` is correct.
- `inflight` is a 1-bit register set by `en`. The captured `qout` is pushed into the FIFO the following cycle.
- FIFO: 2 entries, registered output. `o_data` is the head entry, `o_valid` = not empty. Push and pop in the same cycle are legal, and the count is unchanged.
- Words are delivered exactly once, in address order. The total delivered equals `i_cnt`.
- `addr` holds its last value when `en`=0. `en` is never 1 outside RUN.

## Timing
- Reset values: state IDLE, `o_idle`=1, `o_busy`=0, `o_done`=0, `en`=0, `we`=0, `addr`=0, `o_valid`=0, `o_data`=0, FIFO empty, `inflight`=0.
- Reset takes priority over every other event. Reset mid-operation discards FIFO contents and in-flight data, and no `o_done` is produced.
- Timeline, with cycle 0 being the edge where `i_run` is sampled in IDLE:
  - Cycle 1: `en`=1, `addr`=`i_base`.
  - Cycle 2: `qout` valid and pushed.
  - Cycle 3: `o_valid`=1.
- Throughput with `i_ready` held 1: one word per cycle.
  - Last data transfer at cycle `cnt+2`; `o_done` at cycle `cnt+3`; `o_idle` at cycle `cnt+4`.
- `i_cnt`=0: `o_done` at cycle 1, `o_idle` at cycle 2, no `en`.
- Backpressure: `o_valid`/`o_data` stay stable until accepted. The FIFO never overflows, because issue is gated by credit.

## Configuration
- `BRAM_STREAM_RD_ABORT_EN` defined: adds input `i_abort` (1 bit).
  - `i_abort`=1 in RUN or DRAIN means no further `en` from that cycle onward; the FIFO is flushed and any in-flight word is dropped. This applies even if `i_ready`=1 in the same cycle.
  - The next state is DONE, so `o_done` pulses one cycle later.
  - `i_abort` is ignored in IDLE and DONE.
- Not defined: no `i_abort` port; every accepted run completes all `i_cnt` words.

## Test plan
- BRAM preloaded with `mem[a] = 16'hA500 | a`; run `base`=0, `cnt`=4, `i_ready`=1.
  - Required: `o_data` A500, A501, A502, A503 on cycles 3–6; `o_done` at cycle 7; exactly 4 `en` pulses.
- Wrap: `base`=126, `cnt`=4.
  - Required: `addr` sequence 126, 127, 0, 1; data A57E, A57F, A500, A501.
- Backpressure: `cnt`=100, `i_ready` random at 50% duty.
  - Required: 100 transfers, in order, no duplicates or gaps; FIFO count never exceeds 2; `o_data` stable while stalled.
- Run while busy and zero count:
  - `i_run` pulsed during RUN is ignored, and the transfer count is unchanged.
  - `cnt`=0 gives `o_done` at cycle 1 and no `en`.
- Reset mid-run: assert `rst_n` at cycle 20 of a 100-word run.
  - Required: the next cycle has all outputs at reset values and no `o_done`.
  - A new run with `cnt`=3 then completes normally.
- With `BRAM_STREAM_RD_ABORT_EN` defined: abort at cycle 10 of a 50-word run.
  - Required: no `en` from cycle 10 on, `o_valid`=0 at cycle 11, `o_done` at cycle 11, `o_idle` at cycle 12.

Source files
------------

// File: rtl/bram_stream_rd.sv
// Streams i_cnt consecutive BRAM words from i_base out on a valid/ready port (BRAM_STREAM_RD_ABORT_EN adds i_abort).
// Latency: first word valid 3 cycles after i_run is sampled; one word per cycle when i_ready is held high.
// Backpressure: reads are issued only while the 2-entry output FIFO has credit, so stalls never drop or duplicate data.
module bram_stream_rd #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH-1:0] i_cnt,
`ifdef BRAM_STREAM_RD_ABORT_EN
    input  logic                  i_abort,
`endif
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  en,
    output logic                  we,
    input  logic [DATA_WIDTH-1:0] qout,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   issued_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    inflight_q;
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic                    rd_ptr_q;
    logic                    wr_ptr_q;
    logic [1:0]              fifo_cnt_q;
    logic [1:0]              fifo_cnt_d;
    logic [2:0]              occupancy;
    logic                    abort;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic                    last_issue;
    logic                    issue;

    always_comb begin
`ifdef BRAM_STREAM_RD_ABORT_EN
        abort = i_abort && (state_q == S_RUN || state_q == S_DRAIN);
`else
        abort = 1'b0;
`endif
        pop        = (fifo_cnt_q != 2'd0) && i_ready;
        push       = inflight_q && !abort;
        // Words already owed to the FIFO after this cycle's pop; a new read needs one free slot.
        occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        credit_ok  = occupancy < 3'd2;
        last_issue = (issued_q + ONE) == cnt_q;
        issue      = (state_q == S_RUN) && (issued_q != cnt_q) && credit_ok && !abort;
        fifo_cnt_d = abort ? 2'd0 : (fifo_cnt_q + {1'b0, push} - {1'b0, pop});
        addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            inflight_q <= issue;
            fifo_cnt_q <= fifo_cnt_d;

            if (abort) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr_q] <= qout;
                    wr_ptr_q         <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end

            // The address stays on the last issued word once the run has been fully issued.
            if (issue) begin
                issued_q <= issued_q + ONE;
                if (!last_issue) begin
                    addr_q <= addr_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (i_run) begin
                        cnt_q    <= i_cnt;
                        addr_q   <= i_base;
                        issued_q <= '0;
                        state_q  <= (i_cnt == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_DONE;
                    end else if (issue && last_issue) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_q <= S_DONE;
                    end else if (fifo_cnt_d == 2'd0 && !inflight_q) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_idle  = (state_q == S_IDLE);
    assign o_busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done  = (state_q == S_DONE);
    assign addr    = addr_q;
    assign en      = issue;
    assign we      = 1'b0;
    assign o_valid = (fifo_cnt_q != 2'd0);
    assign o_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_stream_rd.sv
// Scoreboard bench for bram_stream_rd: expected words are queued at run start and checked by a negedge monitor.
module tb_bram_stream_rd;

    localparam int DW  = 16;
    localparam int AW  = 7;
    localparam int MS  = 128;
    localparam int OFF = -10;

    logic          clk;
    logic          rst_n;
    logic          i_run;
    logic [AW-1:0] i_base;
    logic [AW-1:0] i_cnt;
    logic          o_idle;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic [DW-1:0] qout;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
`ifdef BRAM_STREAM_RD_ABORT_EN
    logic          i_abort;
    int            abort_en_cnt;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_xfer = 0;
    int            en_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_log[$];
    logic [DW-1:0] exp_word;
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_dat = '0;
    logic [DW-1:0] mem [MS];

    bram_stream_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_run   (i_run),
        .i_base  (i_base),
        .i_cnt   (i_cnt),
`ifdef BRAM_STREAM_RD_ABORT_EN
        .i_abort (i_abort),
`endif
        .o_idle  (o_idle),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .addr    (addr),
        .en      (en),
        .we      (we),
        .qout    (qout),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM port: one-cycle registered read.
    always @(posedge clk) begin
        if (en) qout <= mem[addr];
    end

    function automatic logic [DW-1:0] mval(input int a);
        logic [AW-1:0] a7;
        a7 = AW'(a);
        return 16'hA500 | {9'd0, a7};
    endfunction

    always @(negedge clk) begin
        if (rst_n == 1'b0) begin
            if (en) begin
                en_cnt++;
                addr_log.push_back(addr);
            end
            if (stall_q) begin
                n_cmp++;
                if (!o_valid || o_data !== stall_dat) begin
                    n_bad++;
                    $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h", o_valid, o_data, stall_dat);
                end
            end
            if (o_valid && i_ready) begin
                n_cmp++;
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_data: got %h, required no transfer", o_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (o_data !== exp_word) begin
                        n_bad++;
                        $display("FAIL stream_data: got %h, required %h", o_data, exp_word);
                    end
                end
            end
            stall_q   = o_valid && !i_ready;
            stall_dat = o_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic check_reset_out();
        chk("rst_o_idle",  int'(o_idle), 1);
        chk("rst_o_busy",  int'(o_busy), 0);
        chk("rst_o_done",  int'(o_done), 0);
        chk("rst_en",      int'(en), 0);
        chk("rst_we",      int'(we), 0);
        chk("rst_addr",    int'(addr), 0);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_data",  int'(o_data), 0);
    endtask

    // Cycle k of a run is the clock period following the k-th edge after i_run was raised.
    task automatic run(input int base, input int cnt, input int rnd_ready, input int poke_cyc,
                       input int rst_cyc, input int abort_cyc, input int budget,
                       output int first_vld, output int done_cyc, output int idle_cyc);
        first_vld = -1;
        done_cyc  = -1;
        idle_cyc  = -1;
        n_xfer    = 0;
        en_cnt    = 0;
        addr_log.delete();
`ifdef BRAM_STREAM_RD_ABORT_EN
        abort_en_cnt = 0;
`endif
        for (int i = 0; i < cnt; i++) exp_q.push_back(mval((base + i) % MS));
        i_base  = AW'(base);
        i_cnt   = AW'(cnt);
        i_ready = 1'b1;
        i_run   = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            i_ready = rnd_ready != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == poke_cyc) begin
                i_run  = 1'b1;
                i_base = AW'(50);
                i_cnt  = AW'(20);
            end else begin
                i_run = 1'b0;
            end
            rst_n = (k == rst_cyc);
            if (k == rst_cyc + 1) exp_q.delete();
`ifdef BRAM_STREAM_RD_ABORT_EN
            i_abort = (k == abort_cyc);
            if (k == abort_cyc + 1) exp_q.delete();
`endif
            @(negedge clk);
            if (k == rst_cyc + 1) check_reset_out();
`ifdef BRAM_STREAM_RD_ABORT_EN
            if (abort_cyc > 0 && k >= abort_cyc && en) abort_en_cnt++;
            if (k == abort_cyc + 1) chk("abort_valid_low", int'(o_valid), 0);
`endif
            if (o_valid && first_vld < 0) first_vld = k;
            if (o_done && done_cyc < 0) done_cyc = k;
            if (o_idle) idle_cyc = k;
            @(posedge clk); #1;
            if (idle_cyc >= 0) break;
        end
        i_ready = 1'b1;
        i_run   = 1'b0;
        rst_n   = 1'b0;
`ifdef BRAM_STREAM_RD_ABORT_EN
        i_abort = 1'b0;
`endif
        chk("run_reached_idle", int'(idle_cyc >= 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish");
        $fatal(1);
    end

    initial begin
        int f, d, idl;
        int wrap_addr [4];
        wrap_addr = '{126, 127, 0, 1};
        for (int a = 0; a < MS; a++) mem[a] = mval(a);
        qout    = '0;
        rst_n   = 1'b1;
        i_run   = 1'b0;
        i_base  = '0;
        i_cnt   = '0;
        i_ready = 1'b1;
`ifdef BRAM_STREAM_RD_ABORT_EN
        i_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_out();
        @(posedge clk); #1;

        // Basic four-word run
        run(0, 4, 0, OFF, OFF, OFF, 40, f, d, idl);
        chk("t1_first_valid", f, 3);
        chk("t1_done_cycle", d, 7);
        chk("t1_idle_cycle", idl, 8);
        chk("t1_en_pulses", en_cnt, 4);
        chk("t1_transfers", n_xfer, 4);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Address wrap at the top of memory
        run(126, 4, 0, OFF, OFF, OFF, 40, f, d, idl);
        chk("t2_addr_count", addr_log.size(), 4);
        for (int j = 0; j < 4; j++)
            chk("t2_addr_seq", (j < addr_log.size()) ? int'(addr_log[j]) : -1, wrap_addr[j]);
        chk("t2_done_cycle", d, 7);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Random backpressure
        run(10, 100, 1, OFF, OFF, OFF, 2000, f, d, idl);
        chk("t3_transfers", n_xfer, 100);
        chk("t3_en_pulses", en_cnt, 100);
        chk("t3_sb_empty", exp_q.size(), 0);

        // i_run while busy is ignored
        run(0, 8, 0, 3, OFF, OFF, 60, f, d, idl);
        chk("t4_transfers", n_xfer, 8);
        chk("t4_en_pulses", en_cnt, 8);
        chk("t4_done_cycle", d, 11);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Zero count
        run(0, 0, 0, OFF, OFF, OFF, 20, f, d, idl);
        chk("t5_done_cycle", d, 1);
        chk("t5_idle_cycle", idl, 2);
        chk("t5_en_pulses", en_cnt, 0);
        chk("t5_no_valid", f, -1);

        // Reset at cycle 20 of a long run, then a short run
        run(0, 100, 0, OFF, 20, OFF, 200, f, d, idl);
        chk("t6_no_done", d, -1);
        chk("t6_idle_cycle", idl, 21);
        chk("t6_transfers", n_xfer, 17);
        chk("t6_sb_empty", exp_q.size(), 0);
        run(5, 3, 0, OFF, OFF, OFF, 40, f, d, idl);
        chk("t7_first_valid", f, 3);
        chk("t7_done_cycle", d, 6);
        chk("t7_transfers", n_xfer, 3);
        chk("t7_sb_empty", exp_q.size(), 0);

`ifdef BRAM_STREAM_RD_ABORT_EN
        run(0, 50, 0, OFF, OFF, 10, 200, f, d, idl);
        chk("t8_done_cycle", d, 11);
        chk("t8_idle_cycle", idl, 12);
        chk("t8_en_after_abort", abort_en_cnt, 0);
        chk("t8_en_pulses", en_cnt, 9);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
